lts_frame_extractor: RTL and testbench

//  Parametrised successor of the LTS-extraction control path in the CSI extractor.

---
 rtl/lts_frame_extractor.sv | 216 +++++++++++++++++++++
 tb/tb_lts_frame_extractor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lts_frame_extractor.sv
// lts_frame_extractor: hysteretic power trigger that sequences external STS/LTS
// detectors and forwards the 2*LTS_LEN samples following the LTS start as one
// AXI-Stream frame tagged with a packet ID.
module lts_frame_extractor #(
  parameter int SAMPLE_W     = 16,
  parameter int PWR_WIN_LOG2 = 4,
  parameter int LTS_LEN      = 64,
  parameter int STS_TIMEOUT  = 400,
  parameter int LTS_TIMEOUT  = 320,
  parameter int PKT_ID_W     = 8
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             s_axis_tvalid,
  input  logic [2*SAMPLE_W-1:0]            s_axis_tdata,
  output logic                             s_axis_tready,
  output logic                             m_axis_tvalid,
  output logic [2*SAMPLE_W-1:0]            m_axis_tdata,
  output logic                             m_axis_tlast,
  output logic [PKT_ID_W-1:0]              m_axis_tuser,
  input  logic                             m_axis_tready,
  input  logic [SAMPLE_W+PWR_WIN_LOG2:0]   power_thresh_in,
  input  logic                             sts_detect_in,
  input  logic                             lts_peak_in,
  output logic                             sts_rst_out,
  output logic                             lts_rst_out,
  output logic                             sts_en_out,
  output logic                             lts_en_out,
  output logic [4:0]                       state_out,
  output logic [PKT_ID_W-1:0]              pkt_count_out,
  output logic [PKT_ID_W-1:0]              timeout_count_out
);

  localparam int MAG_W     = SAMPLE_W + 1;
  localparam int SUM_W     = SAMPLE_W + 1 + PWR_WIN_LOG2;
  localparam int WIN       = 2 ** PWR_WIN_LOG2;
  localparam int TMAX      = (STS_TIMEOUT > LTS_TIMEOUT) ? STS_TIMEOUT : LTS_TIMEOUT;
  localparam int TCNT_W    = $clog2(TMAX + 1);
  localparam int FRAME_LEN = 2 * LTS_LEN;
  localparam int FCNT_W    = $clog2(FRAME_LEN);

  // One-hot encoding doubles as the status word on state_out.
  typedef enum logic [4:0] {
    WAIT_LOW   = 5'b00001,
    WAIT_POWER = 5'b00010,
    SYNC_SHORT = 5'b00100,
    SYNC_LONG  = 5'b01000,
    STREAM     = 5'b10000
  } state_t;

  // Unsigned magnitude; the most negative input maps exactly to 2**(W-1).
  function automatic logic [SAMPLE_W-1:0] abs_val(input logic [SAMPLE_W-1:0] v);
    if (v[SAMPLE_W-1]) begin
      abs_val = ~v + {{(SAMPLE_W-1){1'b0}}, 1'b1};
    end else begin
      abs_val = v;
    end
  endfunction

  state_t              state, state_next;
  logic [MAG_W-1:0]    hist [WIN];
  logic [PWR_WIN_LOG2-1:0] ptr;
  logic [SUM_W-1:0]    sum;
  logic [SUM_W-1:0]    sum_next;
  logic [MAG_W-1:0]    mag;
  logic                trig;
  logic [TCNT_W-1:0]   tcnt;
  logic [FCNT_W-1:0]   frame_cnt;
  logic [PKT_ID_W-1:0] pkt_count;
  logic [PKT_ID_W-1:0] timeout_count;
  logic                pass, beat, hs, frame_last;
  logic                sts_rst_next, lts_rst_next, timeout_hit, frame_done;

  // The LTS start beat is forwarded in the same cycle, so pass-through opens
  // combinationally on lts_peak_in while still in SYNC_LONG.
  assign pass          = (state == STREAM) | ((state == SYNC_LONG) & lts_peak_in);
  assign s_axis_tready = pass ? m_axis_tready : 1'b1;
  assign m_axis_tvalid = pass & s_axis_tvalid;
  assign m_axis_tdata  = pass ? s_axis_tdata : '0;
  assign frame_last    = (frame_cnt == FCNT_W'(FRAME_LEN - 1));
  assign m_axis_tlast  = m_axis_tvalid & frame_last;
  assign m_axis_tuser  = pass ? pkt_count : '0;
  assign beat          = s_axis_tvalid & s_axis_tready;
  assign hs            = m_axis_tvalid & m_axis_tready;

  assign sts_en_out        = (state == SYNC_SHORT);
  assign lts_en_out        = (state == SYNC_LONG);
  assign state_out         = state;
  assign pkt_count_out     = pkt_count;
  assign timeout_count_out = timeout_count;

  assign mag      = {1'b0, abs_val(s_axis_tdata[2*SAMPLE_W-1:SAMPLE_W])}
                  + {1'b0, abs_val(s_axis_tdata[SAMPLE_W-1:0])};
  assign sum_next = sum + {{(SUM_W-MAG_W){1'b0}}, mag}
                  - {{(SUM_W-MAG_W){1'b0}}, hist[ptr]};

  // Sliding-window power sum and hysteretic trigger, advanced on input beats.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < WIN; k++) hist[k] <= '0;
      ptr  <= '0;
      sum  <= '0;
      trig <= 1'b0;
    end else if (beat) begin
      hist[ptr] <= mag;
      ptr       <= ptr + 1'b1;
      sum       <= sum_next;
      if (sum_next > power_thresh_in) begin
        trig <= 1'b1;
      end else if (sum_next < (power_thresh_in >> 1)) begin
        trig <= 1'b0;
      end else begin
        trig <= trig;
      end
    end else begin
      trig <= trig;
    end
  end

  // Next-state logic; event priority is detector pulse, then power loss, then timeout.
  always_comb begin
    state_next   = state;
    sts_rst_next = 1'b0;
    lts_rst_next = 1'b0;
    timeout_hit  = 1'b0;
    frame_done   = 1'b0;
    case (state)
      WAIT_LOW: begin
        if (!trig) state_next = WAIT_POWER;
        else       state_next = WAIT_LOW;
      end
      WAIT_POWER: begin
        if (trig) begin
          state_next   = SYNC_SHORT;
          sts_rst_next = 1'b1;
        end else begin
          state_next = WAIT_POWER;
        end
      end
      SYNC_SHORT: begin
        if (sts_detect_in) begin
          state_next   = SYNC_LONG;
          lts_rst_next = 1'b1;
        end else if (!trig) begin
          state_next = WAIT_POWER;
        end else if (beat && (tcnt == TCNT_W'(STS_TIMEOUT - 1))) begin
          state_next  = WAIT_LOW;
          timeout_hit = 1'b1;
        end else begin
          state_next = SYNC_SHORT;
        end
      end
      SYNC_LONG: begin
        if (beat && lts_peak_in) begin
          state_next = STREAM;
        end else if (!trig) begin
          state_next = WAIT_LOW;
        end else if (beat && (tcnt == TCNT_W'(LTS_TIMEOUT - 1))) begin
          state_next  = WAIT_LOW;
          timeout_hit = 1'b1;
        end else begin
          state_next = SYNC_LONG;
        end
      end
      STREAM: begin
        if (hs && frame_last) begin
          state_next = WAIT_LOW;
          frame_done = 1'b1;
        end else begin
          state_next = STREAM;
        end
      end
      default: state_next = WAIT_POWER;
    endcase
  end

  // State register, detector reset pulses, per-state beat and frame counters, status counters.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state         <= WAIT_POWER;
      sts_rst_out   <= 1'b0;
      lts_rst_out   <= 1'b0;
      tcnt          <= '0;
      frame_cnt     <= '0;
      pkt_count     <= '0;
      timeout_count <= '0;
    end else begin
      state       <= state_next;
      sts_rst_out <= sts_rst_next;
      lts_rst_out <= lts_rst_next;
      if (state_next != state) begin
        tcnt <= '0;
      end else if (beat && ((state == SYNC_SHORT) || (state == SYNC_LONG))) begin
        tcnt <= tcnt + 1'b1;
      end else begin
        tcnt <= tcnt;
      end
      if (hs) begin
        frame_cnt <= frame_done ? '0 : frame_cnt + 1'b1;
      end else begin
        frame_cnt <= frame_cnt;
      end
      if (frame_done) begin
        pkt_count <= pkt_count + 1'b1;
      end else begin
        pkt_count <= pkt_count;
      end
      if (timeout_hit && (timeout_count != {PKT_ID_W{1'b1}})) begin
        timeout_count <= timeout_count + 1'b1;
      end else begin
        timeout_count <= timeout_count;
      end
    end
  end

endmodule

// File: tb/tb_lts_frame_extractor.sv
// Scoreboard bench for lts_frame_extractor: randomized I/Q stimulus, a
// beat-level behavioural reference model, and a monitor on the output stream.
module tb_lts_frame_extractor;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        s_axis_tvalid;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tready;
  logic        m_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tuser;
  logic        m_axis_tready;
  logic [20:0] power_thresh_in;
  logic        sts_detect_in;
  logic        lts_peak_in;
  logic        sts_rst_out, lts_rst_out, sts_en_out, lts_en_out;
  logic [4:0]  state_out;
  logic [7:0]  pkt_count_out, timeout_count_out;

  always #5 clk_in = ~clk_in;

  lts_frame_extractor dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
    .power_thresh_in(power_thresh_in), .sts_detect_in(sts_detect_in), .lts_peak_in(lts_peak_in),
    .sts_rst_out(sts_rst_out), .lts_rst_out(lts_rst_out), .sts_en_out(sts_en_out),
    .lts_en_out(lts_en_out), .state_out(state_out), .pkt_count_out(pkt_count_out),
    .timeout_count_out(timeout_count_out)
  );

  localparam int FRAME = 128;

  typedef struct { logic [31:0] data; logic last; logic [7:0] user; } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int mon_len = 0;
  int mon_total = 0;

  // Reference model state: phases named after the operating modes.
  typedef enum int {P_LOW = 0, P_POWER = 1, P_SHORT = 2, P_LONG = 3, P_STREAM = 4} phase_t;
  phase_t ph;
  int  win[$];
  bit  trig;
  int  tcnt, frame, pkt, tocnt, thr, gbeat;
  bit  exp_sts, exp_lts;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
    end
  endtask

  function automatic void model_reset();
    ph = P_POWER;
    win.delete();
    for (int k = 0; k < 16; k++) win.push_back(0);
    trig = 1'b0; tcnt = 0; frame = 0; pkt = 0; tocnt = 0;
    exp_sts = 1'b0; exp_lts = 1'b0;
    exp_q.delete();
  endfunction

  // amp 0: silence; amp<=4: noise in [-4,4]; otherwise magnitude in [amp/2, amp] with random sign.
  function automatic int gen(input int amp);
    int m;
    if (amp == 0) return 0;
    if (amp <= 4) return int'($urandom_range(0, 8)) - 4;
    m = int'($urandom_range(amp / 2, amp));
    if ($urandom_range(0, 1) == 1) return -m;
    return (m > 32767) ? 32767 : m;
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One clock cycle: drive inputs, check status outputs, advance the model.
  task automatic step(input int amp, input int vpct, input int rpct, input bit sts, input bit peak);
    int i, q, s;
    bit vld, rdy, pass, etr, beat, fwd, nsts, nlts;
    phase_t nph;
    logic [4:0] oh;
    exp_t e;
    i = gen(amp);
    q = gen(amp);
    vld = ($urandom_range(0, 99) < vpct);
    rdy = ($urandom_range(0, 99) < rpct);
    s_axis_tvalid   = vld;
    s_axis_tdata    = {i[15:0], q[15:0]};
    m_axis_tready   = rdy;
    sts_detect_in   = sts;
    lts_peak_in     = peak;
    power_thresh_in = 21'(thr);
    pass = (ph == P_STREAM) || ((ph == P_LONG) && peak);
    etr  = pass ? rdy : 1'b1;
    beat = vld && etr;
    fwd  = pass && vld && rdy;
    #1;
    oh = 5'b00001 << ph;
    chk("state_out", 64'(state_out), 64'(oh));
    chk("s_tready", 64'(s_axis_tready), 64'(etr));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(pass && vld));
    chk("sts_rst", 64'(sts_rst_out), 64'(exp_sts));
    chk("lts_rst", 64'(lts_rst_out), 64'(exp_lts));
    chk("sts_en", 64'(sts_en_out), 64'(ph == P_SHORT));
    chk("lts_en", 64'(lts_en_out), 64'(ph == P_LONG));
    chk("pkt_count", 64'(pkt_count_out), 64'(pkt % 256));
    chk("timeout_count", 64'(timeout_count_out), 64'(tocnt));
    if (fwd) begin
      e.data = {i[15:0], q[15:0]};
      e.last = (frame == FRAME - 1);
      e.user = 8'(pkt);
      exp_q.push_back(e);
    end
    nph = ph; nsts = 1'b0; nlts = 1'b0;
    case (ph)
      P_LOW:    if (!trig) nph = P_POWER;
      P_POWER:  if (trig) begin nph = P_SHORT; nsts = 1'b1; end
      P_SHORT: begin
        if (sts) begin nph = P_LONG; nlts = 1'b1; end
        else if (!trig) nph = P_POWER;
        else if (beat) begin
          tcnt++;
          if (tcnt == 400) begin nph = P_LOW; if (tocnt < 255) tocnt++; end
        end
      end
      P_LONG: begin
        if (beat && peak) begin nph = P_STREAM; frame = 1; end
        else if (!trig) nph = P_LOW;
        else if (beat) begin
          tcnt++;
          if (tcnt == 320) begin nph = P_LOW; if (tocnt < 255) tocnt++; end
        end
      end
      P_STREAM: begin
        if (fwd) begin
          if (frame == FRAME - 1) begin frame = 0; pkt = (pkt + 1) % 256; nph = P_LOW; end
          else frame++;
        end
      end
      default: ;
    endcase
    if (nph != ph) tcnt = 0;
    if (beat) begin
      gbeat++;
      void'(win.pop_front());
      win.push_back(iabs(i) + iabs(q));
      s = 0;
      foreach (win[k]) s += win[k];
      if (s > thr) trig = 1'b1;
      else if (s < thr / 2) trig = 1'b0;
    end
    exp_sts = nsts;
    exp_lts = nlts;
    ph = nph;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) step(0, 100, 100, 1'b0, 1'b0);
  endtask

  // stop: 0 = packet completed, 1 = timeout counted, 2 = frame sample 50 reached.
  task automatic run_scn(input int amp, input int vpct, input int rpct, input int sts_at,
                         input int peak_at, input bit drop10, input int stop, input int max_cyc);
    int pkt0, to0, a;
    bit st, pk;
    pkt0 = pkt; to0 = tocnt; gbeat = 0;
    for (int c = 0; c < max_cyc; c++) begin
      if (stop == 0 && pkt != pkt0) break;
      if (stop == 1 && tocnt != to0) break;
      if (stop == 2 && ph == P_STREAM && frame == 50) break;
      a  = (drop10 && ph == P_STREAM && frame >= 10) ? 0 : amp;
      st = (sts_at >= 0) && (gbeat == sts_at) && (ph == P_SHORT);
      pk = (peak_at >= 0) && (gbeat >= peak_at) && (ph == P_LONG);
      step(a, vpct, rpct, st, pk);
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (rst_in) begin
        mon_len = 0;
      end else if (m_axis_tvalid && m_axis_tready) begin
        mon_total++;
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_output: got data 0x%0h, expected no transfer at %0t", m_axis_tdata, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", 64'(m_axis_tdata), 64'(e.data));
          chk("tlast", 64'(m_axis_tlast), 64'(e.last));
          chk("tuser", 64'(m_axis_tuser), 64'(e.user));
          mon_len++;
          if (m_axis_tlast) begin
            chk("frame_len", 64'(mon_len), 64'(FRAME));
            mon_len = 0;
          end
        end
      end
    end
  end

  initial begin
    int tot0;
    rst_in = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = 32'd0; m_axis_tready = 1'b0;
    sts_detect_in = 1'b0; lts_peak_in = 1'b0; thr = 500; power_thresh_in = 21'd500;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("reset_state", 64'(state_out), 64'(5'b00010));
    chk("reset_s_tready", 64'(s_axis_tready), 64'(1'b1));
    chk("reset_m_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
    chk("reset_pkt", 64'(pkt_count_out), 64'(0));
    rst_in = 1'b0;

    // Noise below threshold: no trigger, no output.
    tot0 = mon_total;
    for (int c = 0; c < 300; c++) step(4, 100, 100, 1'b0, 1'b0);
    chk("noise_state", 64'(state_out), 64'(5'b00010));
    chk("noise_outputs", 64'(mon_total - tot0), 64'(0));

    // Basic packet with full downstream ready.
    run_scn(200, 100, 100, 40, 200, 1'b0, 0, 1000);
    chk("pkt1_count", 64'(pkt_count_out), 64'(1));
    chk("pkt1_state", 64'(state_out), 64'(5'b00001));
    idle(40);

    // Full-scale samples, 50% downstream backpressure, gappy input.
    run_scn(32768, 90, 50, 40, 200, 1'b0, 0, 3000);
    chk("pkt2_count", 64'(pkt_count_out), 64'(2));
    idle(40);

    // STS timeout then power drop.
    run_scn(200, 100, 100, -1, -1, 1'b0, 1, 600);
    chk("sts_to_state", 64'(state_out), 64'(5'b00001));
    chk("sts_to_count", 64'(timeout_count_out), 64'(1));
    for (int c = 0; c < 100 && ph != P_POWER; c++) step(0, 100, 100, 1'b0, 1'b0);
    chk("sts_to_recover", 64'(state_out), 64'(5'b00010));

    // Power lost at frame sample 10: frame still completes.
    run_scn(200, 100, 100, 40, 200, 1'b0 | 1'b1, 0, 1000);
    chk("pkt3_count", 64'(pkt_count_out), 64'(3));
    idle(40);

    // LTS timeout.
    run_scn(200, 100, 100, 40, -1, 1'b0, 1, 800);
    chk("lts_to_count", 64'(timeout_count_out), 64'(2));
    idle(40);

    // Reset in the middle of a frame, then a clean packet.
    run_scn(200, 100, 100, 40, 200, 1'b0, 2, 1000);
    chk("abort_reached", 64'(ph == P_STREAM && frame == 50), 64'(1'b1));
    rst_in = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    chk("arst_state", 64'(state_out), 64'(5'b00010));
    chk("arst_m_tvalid", 64'(m_axis_tvalid), 64'(1'b0));
    chk("arst_s_tready", 64'(s_axis_tready), 64'(1'b1));
    chk("arst_pkt", 64'(pkt_count_out), 64'(0));
    chk("arst_timeouts", 64'(timeout_count_out), 64'(0));
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    run_scn(200, 100, 100, 40, 200, 1'b0, 0, 1000);
    chk("post_reset_pkt", 64'(pkt_count_out), 64'(1));
    idle(10);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
